// File: rtl/sdf_ct_feeder.sv
// SDF NTT input commutator for one DIT Cooley-Tukey stage.
// Buffers the first half of each 2*D block and pairs it with the second half.
module sdf_ct_feeder #(
    parameter int LOGQ  = 64,
    parameter int LOGN  = 12,
    parameter int STAGE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [LOGQ-1:0] in_data,
    output logic            out_valid,
    output logic [LOGQ-1:0] out_a,
    output logic [LOGQ-1:0] out_b,
    output logic [LOGN-2:0] out_tw_idx,
    output logic            out_first,
    output logic            out_last
);

    localparam int CW = LOGN - STAGE;
    localparam int JW = (CW > 1) ? CW - 1 : 1;
    localparam int D  = 1 << (LOGN - 1 - STAGE);
    localparam int TW = LOGN - 1;

    logic [CW-1:0]   cnt;
    logic [JW-1:0]   j;
    logic            phase;
    logic            pair_acc;
    logic [LOGQ-1:0] mem [0:D-1];
    logic [LOGQ-1:0] rd_data;
    logic [TW-1:0]   tw_next;

    assign phase = cnt[CW-1];

    generate
        if (CW > 1) begin : g_j
            assign j = cnt[CW-2:0];
        end else begin : g_j0
            assign j = '0;
        end
    endgenerate

    assign rd_data  = mem[j];
    assign pair_acc = in_valid & phase;
    assign tw_next  = TW'(j) << STAGE;

    // block position counter, advances on accepted samples only
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (in_valid) begin
            cnt <= cnt + CW'(1);
        end
    end

    // delay line, read-before-write at entry j; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            mem[j] <= in_data;
        end
    end

    // butterfly pair register, holds its value across stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_tw_idx <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            out_valid <= pair_acc;
            if (pair_acc) begin
                out_a      <= rd_data;
                out_b      <= in_data;
                out_tw_idx <= tw_next;
                out_first  <= (j == '0);
                out_last   <= (j == JW'(D - 1));
            end
        end
    end

endmodule

// File: tb/tb_sdf_ct_feeder.sv
// Directed self-checking bench for sdf_ct_feeder.
// Main instance uses D=4; a second instance covers D=1.
module tb_sdf_ct_feeder;

    logic        clk = 1'b0;
    logic        rst, in_valid;
    logic [15:0] in_data;
    logic        out_valid, out_first, out_last;
    logic [15:0] out_a, out_b;
    logic [2:0]  out_tw_idx;

    logic        rst1, in_valid1;
    logic [15:0] in_data1;
    logic        out_valid1, out_first1, out_last1;
    logic [15:0] out_a1, out_b1;
    logic [2:0]  out_tw_idx1;

    int checks = 0;
    int errors = 0;

    logic [15:0] ea, eb;
    logic [2:0]  etw;
    logic        ef, el;

    always #5 clk = ~clk;

    sdf_ct_feeder #(.LOGQ(16), .LOGN(4), .STAGE(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
        .out_tw_idx(out_tw_idx), .out_first(out_first), .out_last(out_last)
    );

    sdf_ct_feeder #(.LOGQ(16), .LOGN(4), .STAGE(3)) u1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_data(in_data1),
        .out_valid(out_valid1), .out_a(out_a1), .out_b(out_b1),
        .out_tw_idx(out_tw_idx1), .out_first(out_first1), .out_last(out_last1)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [15:0] d, input logic r);
        rst = r;
        in_valid = v;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic hold_chk();
        chk("hold_v", 64'(out_valid), 64'd0);
        chk("hold_a", 64'(out_a), 64'(ea));
        chk("hold_b", 64'(out_b), 64'(eb));
        chk("hold_tw", 64'(out_tw_idx), 64'(etw));
        chk("hold_f", 64'(out_first), 64'(ef));
        chk("hold_l", 64'(out_last), 64'(el));
    endtask

    // accept sample k (0..7) of a block whose first sample is base
    task automatic push(input int k, input logic [15:0] base);
        int p;
        tick(1'b1, base + 16'(k), 1'b0);
        if (k >= 4) begin
            p   = k - 4;
            ea  = base + 16'(p);
            eb  = base + 16'(k);
            etw = 3'(p * 2);
            ef  = (p == 0);
            el  = (p == 3);
            chk("pair_v", 64'(out_valid), 64'd1);
            chk("pair_a", 64'(out_a), 64'(ea));
            chk("pair_b", 64'(out_b), 64'(eb));
            chk("pair_tw", 64'(out_tw_idx), 64'(etw));
            chk("pair_f", 64'(out_first), 64'(ef));
            chk("pair_l", 64'(out_last), 64'(el));
        end else begin
            chk("fill_v", 64'(out_valid), 64'd0);
        end
    endtask

    task automatic do_reset();
        tick(1'b0, 16'd0, 1'b1);
        tick(1'b0, 16'd0, 1'b1);
        ea = '0; eb = '0; etw = '0; ef = 1'b0; el = 1'b0;
    endtask

    initial begin
        int k;
        int it;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0;

        // reset state
        do_reset();
        hold_chk();

        // continuous stream, markers
        for (int i = 0; i < 16; i++) push(i % 8, 16'(i - i % 8));

        // random gaps
        do_reset();
        k = 0;
        it = 0;
        while (k < 16 && it < 400) begin
            if ($urandom_range(0, 9) < 4) begin
                tick(1'b0, 16'hdead, 1'b0);
                hold_chk();
            end else begin
                push(k % 8, 16'(k - k % 8));
                k++;
            end
            it++;
        end
        chk("gap_done", 64'(k), 64'd16);

        // reset mid-PAIR with rst and in_valid both high
        do_reset();
        for (int i = 0; i < 6; i++) push(i, 16'd0);
        tick(1'b1, 16'd99, 1'b1);
        chk("rst_v", 64'(out_valid), 64'd0);
        ea = '0; eb = '0; etw = '0; ef = 1'b0; el = 1'b0;
        hold_chk();
        for (int i = 0; i < 8; i++) push(i, 16'd100);

        // back-to-back blocks
        do_reset();
        for (int i = 0; i < 32; i++) push(i % 8, 16'(i - i % 8));

        // D=1 instance
        rst1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid1 = 1'b1;
            in_data1 = 16'(i);
            @(posedge clk);
            #1;
            if (i % 2 == 1) begin
                chk("d1_v", 64'(out_valid1), 64'd1);
                chk("d1_a", 64'(out_a1), 64'(i - 1));
                chk("d1_b", 64'(out_b1), 64'(i));
                chk("d1_tw", 64'(out_tw_idx1), 64'd0);
                chk("d1_f", 64'(out_first1), 64'd1);
                chk("d1_l", 64'(out_last1), 64'd1);
            end else begin
                chk("d1_fill", 64'(out_valid1), 64'd0);
            end
        end
        in_valid1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
